nexus_keccak_sched: RTL and testbench
=====================================

Name: nexus_keccak_sched

Overview:
- Work scheduler for the fully unrolled 3-block Keccak-1024 mining pipeline.
- Latches one 1024-bit work header and sweeps a 64-bit nonce field across a programmed range, issuing one candidate per clock into the pipeline.
- Keeps each candidate's nonce and valid tag aligned with the pipeline's 64-bit result word and compares that word against a target.
- Hands hits to the host over a valid/ready result port. The pipeline cannot stall, so hits that arrive while the result slot is full are counted and dropped.

Parameters:
PIPE_LATENCY, 72, cycles from PipeIn presented to matching PipeOut (3 blocks x 24 rounds)
NONCE_LSB, 960, bit position of the 64-bit nonce field inside WorkIn/PipeIn
DROP_W, 16, width of DropCount (saturating)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
WorkIn  in  1024  header template; nonce field ignored
NonceStart  in  64  first nonce
NonceEnd  in  64  last nonce, inclusive
Target  in  64  hit if PipeOut <= Target, unsigned
Start  in  1  pulse: latch WorkIn/NonceStart/NonceEnd/Target, begin sweep
Stop  in  1  pulse: cease issuing, drain
PipeIn  out  1024  registered pipeline input
PipeOut  in  64  pipeline result word
Busy  out  1  high in RUN or DRAIN
Done  out  1  one-cycle pulse when the last valid tag retires
FoundValid  out  1  result slot occupied
FoundReady  in  1  host accepts result
FoundNonce  out  64  nonce of the hit
FoundHash  out  64  PipeOut value of the hit
DropCount  out  DROP_W  hits lost while the slot was full, saturating
HashCount  out  48  valid tags retired since the last Start

Behaviour:
- Reset (async, rst_n=0): all of the following are cleared.
  - State=IDLE; PipeIn=0; tag valid line all 0.
  - Busy=0, Done=0, FoundValid=0, FoundNonce=0, FoundHash=0, DropCount=0, HashCount=0.
  - Reset mid-sweep discards all in-flight tags; no Done is produced.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - Start -> RUN.
  - Stop is ignored.
- RUN:
  - Each cycle PipeIn = work with its nonce field = cur nonce; the tag for that cycle is valid.
  - Cur nonce increments mod 2^64. If NonceEnd < NonceStart, the sweep wraps through 0.
  - Issuing the nonce equal to NonceEnd -> DRAIN on the next cycle. NonceStart==NonceEnd issues exactly 1 candidate.
  - Stop -> DRAIN. The candidate presented in the Stop cycle is the last valid one.
- DRAIN:
  - PipeIn holds its last value; issued tags are invalid.
  - When the valid line is empty: Done pulses for 1 cycle, then -> IDLE.
- Start in RUN or DRAIN restarts the sweep:
  - Relatch all inputs and invalidate every in-flight tag on the same edge.
  - No Done pulse for the aborted sweep.
  - HashCount clears to 0. DropCount and the result slot are retained.
- Start and Stop in the same cycle: Start wins.
- Start timing: sampled at edge E; the first candidate is presented during the cycle after E.
- Tag alignment:
  - A candidate presented in cycle t has its PipeOut valid in cycle t+PIPE_LATENCY.
  - The tag delay line (valid bit + 64-bit nonce) has depth PIPE_LATENCY.
- Compare: in cycle t+PIPE_LATENCY, evaluate valid && (PipeOut <= Target), using the Target latched at Start.
  - Valid tag: HashCount increments.
  - Hit with slot empty, or slot being accepted this cycle (FoundValid && FoundReady): the slot loads nonce and hash, and FoundValid=1 on the next cycle (earliest t+PIPE_LATENCY+1).
  - Hit with slot full and not accepted: DropCount increments, saturating at all ones.
- Result handshake:
  - FoundNonce and FoundHash are stable while FoundValid=1 && FoundReady=0.
  - FoundValid && FoundReady clears the slot unless a new hit loads it in the same cycle.
- Done and the hit of the final candidate are independent: Done may pulse while FoundValid=1.

Test Plan:
1. Start, NonceStart=0, NonceEnd=9, Target=all ones -> 10 candidates on consecutive cycles with nonce fields 0..9; first hit FoundValid at Start edge +PIPE_LATENCY+2; FoundReady=1 held -> FoundNonce 0..9 in order; DropCount=0; HashCount=10; one Done pulse.
2. Target=0, nonce range 100..199, bench model forces PipeOut=0 for nonce 150 only -> single result FoundNonce=150, FoundHash=0; HashCount=100.
3. Target=all ones, range 0..4, FoundReady=0 -> FoundNonce=0 held stable; DropCount=4; Done still pulses.
4. NonceStart=FFFF_FFFF_FFFF_FFFE, NonceEnd=1 -> issued nonces FFFE, FFFF, 0, 1 (64-bit); HashCount=4.
5. Stop asserted on the 5th RUN cycle of a 0..999 sweep -> exactly 5 valid tags retire; Done arrives PIPE_LATENCY cycles after the last valid candidate.
6. Start again 10 cycles into a sweep, with new NonceStart=500 -> no results with nonce < 500; no Done for the first sweep; rst_n pulse mid-sweep -> all outputs 0 immediately, Busy=0.

Source files
------------

// File: rtl/nexus_keccak_sched.sv
// Nonce sweep scheduler for the unrolled 3-block Keccak-1024 mining pipeline.
// Issues one candidate per clock, tracks its tag through the pipeline and captures hits.
module nexus_keccak_sched #(
  parameter int PIPE_LATENCY = 72,
  parameter int NONCE_LSB    = 960,
  parameter int DROP_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1023:0]     WorkIn,
  input  logic [63:0]       NonceStart,
  input  logic [63:0]       NonceEnd,
  input  logic [63:0]       Target,
  input  logic              Start,
  input  logic              Stop,
  output logic [1023:0]     PipeIn,
  input  logic [63:0]       PipeOut,
  output logic              Busy,
  output logic              Done,
  output logic              FoundValid,
  input  logic              FoundReady,
  output logic [63:0]       FoundNonce,
  output logic [63:0]       FoundHash,
  output logic [DROP_W-1:0] DropCount,
  output logic [47:0]       HashCount
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    logic [DROP_W-1:0] r;
    if (v == {DROP_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + DROP_W'(1);
    end
    return r;
  endfunction

  state_e              state_q, state_d;
  logic [1023:0]       work_q, work_d;
  logic [1023:0]       pipe_in_q, pipe_in_d;
  logic [63:0]         end_q, end_d;
  logic [63:0]         target_q, target_d;
  logic [63:0]         cur_q, cur_d;
  logic                iss_vld_q, iss_vld_d;
  logic [PIPE_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [63:0]         tag_nonce_q [PIPE_LATENCY];
  logic [63:0]         tag_nonce_d [PIPE_LATENCY];
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fv_q, fv_d;
  logic [63:0]         fnonce_q, fnonce_d;
  logic [63:0]         fhash_q, fhash_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [47:0]         hcnt_q, hcnt_d;

  logic retire_s;
  logic hit_s;
  logic accept_s;
  logic drain_last_s;

  assign retire_s = tag_vld_q[PIPE_LATENCY-1];
  assign hit_s    = retire_s && (PipeOut <= target_q);
  assign accept_s = fv_q && FoundReady;
  // Done is registered, so it is raised one cycle early: when only the youngest tag,
  // about to enter the compare stage, remains in flight.
  assign drain_last_s = !iss_vld_q && (tag_vld_q[PIPE_LATENCY-3:0] == '0);

  // Sweep control, issue path and tag delay line next-state.
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    end_d     = end_q;
    target_d  = target_q;
    cur_d     = cur_q;
    pipe_in_d = pipe_in_q;
    iss_vld_d = 1'b0;
    done_d    = 1'b0;
    tag_vld_d = {tag_vld_q[PIPE_LATENCY-2:0], iss_vld_q};
    tag_nonce_d[0] = pipe_in_q[NONCE_LSB +: 64];
    for (int i = 1; i < PIPE_LATENCY; i++) begin
      tag_nonce_d[i] = tag_nonce_q[i-1];
    end

    if (Start) begin
      work_d    = WorkIn;
      end_d     = NonceEnd;
      target_d  = Target;
      cur_d     = NonceStart;
      tag_vld_d = '0;
      state_d   = ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          pipe_in_d = work_q;
          pipe_in_d[NONCE_LSB +: 64] = cur_q;
          iss_vld_d = 1'b1;
          cur_d     = cur_q + 64'd1;
          if (Stop || (cur_q == end_q)) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (drain_last_s) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Result slot, drop counter and retired-hash counter next-state.
  always_comb begin
    fv_d     = fv_q;
    fnonce_d = fnonce_q;
    fhash_d  = fhash_q;
    drop_d   = drop_q;

    if (hit_s && (!fv_q || accept_s)) begin
      fv_d     = 1'b1;
      fnonce_d = tag_nonce_q[PIPE_LATENCY-1];
      fhash_d  = PipeOut;
    end else if (hit_s) begin
      drop_d = sat_inc(drop_q);
    end else if (accept_s) begin
      fv_d = 1'b0;
    end else begin
      fv_d = fv_q;
    end

    if (Start) begin
      hcnt_d = 48'd0;
    end else if (retire_s) begin
      hcnt_d = hcnt_q + 48'd1;
    end else begin
      hcnt_d = hcnt_q;
    end
  end

  // All state registers; reset discards every in-flight tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      work_q    <= '0;
      end_q     <= '0;
      target_q  <= '0;
      cur_q     <= '0;
      pipe_in_q <= '0;
      iss_vld_q <= 1'b0;
      tag_vld_q <= '0;
      for (int i = 0; i < PIPE_LATENCY; i++) begin
        tag_nonce_q[i] <= '0;
      end
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fv_q      <= 1'b0;
      fnonce_q  <= '0;
      fhash_q   <= '0;
      drop_q    <= '0;
      hcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      end_q     <= end_d;
      target_q  <= target_d;
      cur_q     <= cur_d;
      pipe_in_q <= pipe_in_d;
      iss_vld_q <= iss_vld_d;
      tag_vld_q <= tag_vld_d;
      for (int i = 0; i < PIPE_LATENCY; i++) begin
        tag_nonce_q[i] <= tag_nonce_d[i];
      end
      busy_q    <= busy_d;
      done_q    <= done_d;
      fv_q      <= fv_d;
      fnonce_q  <= fnonce_d;
      fhash_q   <= fhash_d;
      drop_q    <= drop_d;
      hcnt_q    <= hcnt_d;
    end
  end

  assign PipeIn     = pipe_in_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign FoundValid = fv_q;
  assign FoundNonce = fnonce_q;
  assign FoundHash  = fhash_q;
  assign DropCount  = drop_q;
  assign HashCount  = hcnt_q;

endmodule

// File: tb/tb_nexus_keccak_sched.sv
// Directed bench for nexus_keccak_sched with a behavioural fixed-latency pipeline model.
module tb_nexus_keccak_sched;
  localparam int L = 72;
  localparam logic [63:0] HK = 64'hA5A5_5A5A_C3C3_3C3C;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1023:0] WorkIn = '0;
  logic [63:0]   NonceStart = '0, NonceEnd = '0, Target = '0;
  logic          Start = 1'b0, Stop = 1'b0, FoundReady = 1'b0;
  logic [1023:0] PipeIn;
  logic [63:0]   PipeOut;
  logic          Busy, Done, FoundValid;
  logic [63:0]   FoundNonce, FoundHash;
  logic [15:0]   DropCount;
  logic [47:0]   HashCount;

  int cmp_n = 0;
  int err_n = 0;
  int hmode = 0;
  logic [1023:0] work_v;
  logic [63:0] hist [L];
  logic [63:0] rn_q[$];
  logic [63:0] rh_q[$];
  int done_total = 0;

  nexus_keccak_sched dut (
    .clk(clk), .rst_n(rst_n), .WorkIn(WorkIn), .NonceStart(NonceStart),
    .NonceEnd(NonceEnd), .Target(Target), .Start(Start), .Stop(Stop),
    .PipeIn(PipeIn), .PipeOut(PipeOut), .Busy(Busy), .Done(Done),
    .FoundValid(FoundValid), .FoundReady(FoundReady), .FoundNonce(FoundNonce),
    .FoundHash(FoundHash), .DropCount(DropCount), .HashCount(HashCount)
  );

  always #5 clk = ~clk;

  // Pipeline model: the nonce presented in a cycle yields its hash L cycles later.
  always @(posedge clk) begin
    hist[0] <= PipeIn[1023:960];
    for (int i = 1; i < L; i++) hist[i] <= hist[i-1];
  end

  always_comb begin
    if (hmode == 1) PipeOut = (hist[L-1] == 64'd150) ? 64'd0 : ONES;
    else            PipeOut = hist[L-1] ^ HK;
  end

  // Host-side monitor: log accepted results and Done pulses.
  always @(posedge clk) begin
    if (FoundValid && FoundReady) begin
      rn_q.push_back(FoundNonce);
      rh_q.push_back(FoundHash);
    end
    if (Done) done_total <= done_total + 1;
  end

  function automatic logic [63:0] res_n(input int idx);
    return (idx < rn_q.size()) ? rn_q[idx] : 64'hDEAD_0000_0000_BEEF;
  endfunction

  function automatic logic [63:0] res_h(input int idx);
    return (idx < rh_q.size()) ? rh_q[idx] : 64'hDEAD_0000_0000_BEEF;
  endfunction

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  // Pulses Start for one edge; returns in the first cycle after the sampling edge.
  task automatic start_sweep(input logic [63:0] ns, input logic [63:0] ne, input logic [63:0] tg);
    WorkIn = work_v;
    NonceStart = ns;
    NonceEnd = ne;
    Target = tg;
    Start = 1'b1;
    step;
    Start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step; step;
    cmp_n++; if (PipeIn !== 1024'd0) begin err_n++; $display("FAIL reset_pipein: got %h expected 0", PipeIn[1023:960]); end
    cmp_n++; if ({Busy, Done, FoundValid} !== 3'b000) begin err_n++; $display("FAIL reset_flags: got %b expected 000", {Busy, Done, FoundValid}); end
    cmp_n++; if ({FoundNonce, FoundHash} !== 128'd0) begin err_n++; $display("FAIL reset_found: got %h/%h expected 0/0", FoundNonce, FoundHash); end
    cmp_n++; if ({DropCount, HashCount} !== 64'd0) begin err_n++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", DropCount, HashCount); end
    rst_n = 1'b1;
    step; step;
  endtask

  task automatic test_basic;
    int base = rn_q.size();
    int dbase = done_total;
    int first_fv = -1;
    int done_k = -1;
    hmode = 0;
    FoundReady = 1'b1;
    start_sweep(64'd0, 64'd9, ONES);
    for (int k = 0; k < 200; k++) begin
      if (k >= 1 && k <= 10) begin
        cmp_n++; if (PipeIn[1023:960] !== 64'(k - 1)) begin err_n++; $display("FAIL basic_nonce k=%0d: got %h expected %h", k, PipeIn[1023:960], 64'(k - 1)); end
        cmp_n++; if (PipeIn[959:0] !== work_v[959:0]) begin err_n++; $display("FAIL basic_header k=%0d: got %h expected %h", k, PipeIn[63:0], work_v[63:0]); end
      end
      if (k == 1) begin
        cmp_n++; if (Busy !== 1'b1) begin err_n++; $display("FAIL basic_busy: got %b expected 1", Busy); end
      end
      if (FoundValid && first_fv < 0) first_fv = k;
      if (Done && done_k < 0) done_k = k;
      if (done_k >= 0 && k >= done_k + 3) break;
      step;
    end
    cmp_n++; if (first_fv !== L + 2) begin err_n++; $display("FAIL basic_first_found: got %0d expected %0d", first_fv, L + 2); end
    cmp_n++; if (done_k !== L + 10) begin err_n++; $display("FAIL basic_done_cycle: got %0d expected %0d", done_k, L + 10); end
    cmp_n++; if (rn_q.size() - base !== 10) begin err_n++; $display("FAIL basic_result_count: got %0d expected 10", rn_q.size() - base); end
    for (int i = 0; i < 10; i++) begin
      cmp_n++; if (res_n(base + i) !== 64'(i) || res_h(base + i) !== (64'(i) ^ HK)) begin
        err_n++; $display("FAIL basic_result %0d: got %h/%h expected %h/%h", i, res_n(base + i), res_h(base + i), 64'(i), 64'(i) ^ HK);
      end
    end
    cmp_n++; if (DropCount !== 16'd0) begin err_n++; $display("FAIL basic_drop: got %0d expected 0", DropCount); end
    cmp_n++; if (HashCount !== 48'd10) begin err_n++; $display("FAIL basic_hashcount: got %0d expected 10", HashCount); end
    cmp_n++; if (done_total - dbase !== 1) begin err_n++; $display("FAIL basic_done_count: got %0d expected 1", done_total - dbase); end
    cmp_n++; if (Busy !== 1'b0) begin err_n++; $display("FAIL basic_idle: got Busy=%b expected 0", Busy); end
  endtask

  task automatic test_target;
    int base = rn_q.size();
    int done_k = -1;
    hmode = 1;
    FoundReady = 1'b1;
    start_sweep(64'd100, 64'd199, 64'd0);
    for (int k = 0; k < 300; k++) begin
      if (Done && done_k < 0) done_k = k;
      if (done_k >= 0 && k >= done_k + 3) break;
      step;
    end
    cmp_n++; if (done_k !== L + 100) begin err_n++; $display("FAIL target_done_cycle: got %0d expected %0d", done_k, L + 100); end
    cmp_n++; if (rn_q.size() - base !== 1) begin err_n++; $display("FAIL target_result_count: got %0d expected 1", rn_q.size() - base); end
    cmp_n++; if (res_n(base) !== 64'd150 || res_h(base) !== 64'd0) begin err_n++; $display("FAIL target_result: got %h/%h expected 96/0", res_n(base), res_h(base)); end
    cmp_n++; if (HashCount !== 48'd100) begin err_n++; $display("FAIL target_hashcount: got %0d expected 100", HashCount); end
  endtask

  task automatic test_backpressure;
    int base = rn_q.size();
    int dbase = done_total;
    int done_k = -1;
    hmode = 0;
    FoundReady = 1'b0;
    start_sweep(64'd0, 64'd4, ONES);
    for (int k = 0; k < 200; k++) begin
      if (FoundValid) begin
        cmp_n++; if (FoundNonce !== 64'd0 || FoundHash !== HK) begin err_n++; $display("FAIL bp_hold k=%0d: got %h/%h expected 0/%h", k, FoundNonce, FoundHash, HK); end
      end
      if (Done && done_k < 0) done_k = k;
      if (done_k >= 0 && k >= done_k + 3) break;
      step;
    end
    cmp_n++; if (done_k !== L + 5) begin err_n++; $display("FAIL bp_done_cycle: got %0d expected %0d", done_k, L + 5); end
    cmp_n++; if (DropCount !== 16'd4) begin err_n++; $display("FAIL bp_drop: got %0d expected 4", DropCount); end
    cmp_n++; if (FoundValid !== 1'b1) begin err_n++; $display("FAIL bp_slot_full: got %b expected 1", FoundValid); end
    cmp_n++; if (done_total - dbase !== 1) begin err_n++; $display("FAIL bp_done_count: got %0d expected 1", done_total - dbase); end
    FoundReady = 1'b1;
    step; step;
    cmp_n++; if (rn_q.size() - base !== 1 || res_n(base) !== 64'd0) begin err_n++; $display("FAIL bp_drain: got %0d results first %h expected 1 results first 0", rn_q.size() - base, res_n(base)); end
    cmp_n++; if (FoundValid !== 1'b0) begin err_n++; $display("FAIL bp_slot_empty: got %b expected 0", FoundValid); end
  endtask

  task automatic test_wrap;
    int base = rn_q.size();
    int done_k = -1;
    logic [63:0] exp_n [4];
    exp_n[0] = 64'hFFFF_FFFF_FFFF_FFFE;
    exp_n[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_n[2] = 64'd0;
    exp_n[3] = 64'd1;
    hmode = 0;
    FoundReady = 1'b1;
    start_sweep(64'hFFFF_FFFF_FFFF_FFFE, 64'd1, ONES);
    for (int k = 0; k < 200; k++) begin
      if (k >= 1 && k <= 4) begin
        cmp_n++; if (PipeIn[1023:960] !== exp_n[k-1]) begin err_n++; $display("FAIL wrap_nonce k=%0d: got %h expected %h", k, PipeIn[1023:960], exp_n[k-1]); end
      end
      if (Done && done_k < 0) done_k = k;
      if (done_k >= 0 && k >= done_k + 3) break;
      step;
    end
    cmp_n++; if (rn_q.size() - base !== 4) begin err_n++; $display("FAIL wrap_result_count: got %0d expected 4", rn_q.size() - base); end
    for (int i = 0; i < 4; i++) begin
      cmp_n++; if (res_n(base + i) !== exp_n[i]) begin err_n++; $display("FAIL wrap_result %0d: got %h expected %h", i, res_n(base + i), exp_n[i]); end
    end
    cmp_n++; if (HashCount !== 48'd4) begin err_n++; $display("FAIL wrap_hashcount: got %0d expected 4", HashCount); end
    cmp_n++; if (DropCount !== 16'd4) begin err_n++; $display("FAIL wrap_drop_retained: got %0d expected 4", DropCount); end
  endtask

  task automatic test_stop;
    int base = rn_q.size();
    int done_k = -1;
    hmode = 0;
    FoundReady = 1'b1;
    start_sweep(64'd0, 64'd999, ONES);
    for (int k = 0; k < 200; k++) begin
      if (k == 4) Stop = 1'b1;
      if (k == 5) Stop = 1'b0;
      if (k == 6) begin
        cmp_n++; if (PipeIn[1023:960] !== 64'd4) begin err_n++; $display("FAIL stop_hold: got %h expected 4", PipeIn[1023:960]); end
        cmp_n++; if (Busy !== 1'b1) begin err_n++; $display("FAIL stop_busy: got %b expected 1", Busy); end
      end
      if (Done && done_k < 0) done_k = k;
      if (done_k >= 0 && k >= done_k + 3) break;
      step;
    end
    cmp_n++; if (done_k !== L + 5) begin err_n++; $display("FAIL stop_done_cycle: got %0d expected %0d", done_k, L + 5); end
    cmp_n++; if (HashCount !== 48'd5) begin err_n++; $display("FAIL stop_hashcount: got %0d expected 5", HashCount); end
    cmp_n++; if (rn_q.size() - base !== 5 || res_n(base + 4) !== 64'd4) begin err_n++; $display("FAIL stop_results: got %0d results last %h expected 5 results last 4", rn_q.size() - base, res_n(base + 4)); end
  endtask

  task automatic test_restart;
    int base = rn_q.size();
    int dbase = done_total;
    int done_k = -1;
    hmode = 0;
    FoundReady = 1'b1;
    start_sweep(64'd0, 64'd999, ONES);
    for (int k = 0; k < 10; k++) step;
    start_sweep(64'd500, 64'd509, ONES);
    for (int k = 0; k < 200; k++) begin
      if (Done && done_k < 0) done_k = k;
      if (done_k >= 0 && k >= done_k + 3) break;
      step;
    end
    cmp_n++; if (done_k !== L + 10) begin err_n++; $display("FAIL restart_done_cycle: got %0d expected %0d", done_k, L + 10); end
    cmp_n++; if (done_total - dbase !== 1) begin err_n++; $display("FAIL restart_done_count: got %0d expected 1", done_total - dbase); end
    cmp_n++; if (rn_q.size() - base !== 10) begin err_n++; $display("FAIL restart_result_count: got %0d expected 10", rn_q.size() - base); end
    for (int i = 0; i < 10; i++) begin
      cmp_n++; if (res_n(base + i) !== 64'(500 + i)) begin err_n++; $display("FAIL restart_result %0d: got %h expected %h", i, res_n(base + i), 64'(500 + i)); end
    end
    cmp_n++; if (HashCount !== 48'd10) begin err_n++; $display("FAIL restart_hashcount: got %0d expected 10", HashCount); end
  endtask

  task automatic test_reset_mid;
    int base;
    int dbase;
    hmode = 0;
    FoundReady = 1'b1;
    start_sweep(64'd0, 64'd999, ONES);
    for (int k = 0; k < 80; k++) step;
    cmp_n++; if (FoundValid !== 1'b1 || Busy !== 1'b1) begin err_n++; $display("FAIL rstmid_pre: got FoundValid=%b Busy=%b expected 1/1", FoundValid, Busy); end
    rst_n = 1'b0;
    #1;
    cmp_n++; if (PipeIn !== 1024'd0) begin err_n++; $display("FAIL rstmid_pipein: got %h expected 0", PipeIn[1023:960]); end
    cmp_n++; if ({Busy, Done, FoundValid} !== 3'b000) begin err_n++; $display("FAIL rstmid_flags: got %b expected 000", {Busy, Done, FoundValid}); end
    cmp_n++; if ({FoundNonce, FoundHash} !== 128'd0) begin err_n++; $display("FAIL rstmid_found: got %h/%h expected 0/0", FoundNonce, FoundHash); end
    cmp_n++; if ({DropCount, HashCount} !== 64'd0) begin err_n++; $display("FAIL rstmid_counts: got %0d/%0d expected 0/0", DropCount, HashCount); end
    step;
    rst_n = 1'b1;
    base = rn_q.size();
    dbase = done_total;
    for (int k = 0; k < 150; k++) step;
    cmp_n++; if (done_total - dbase !== 0) begin err_n++; $display("FAIL rstmid_no_done: got %0d expected 0", done_total - dbase); end
    cmp_n++; if (rn_q.size() - base !== 0 || FoundValid !== 1'b0) begin err_n++; $display("FAIL rstmid_no_results: got %0d results FoundValid=%b expected 0/0", rn_q.size() - base, FoundValid); end
    cmp_n++; if (HashCount !== 48'd0 || Busy !== 1'b0) begin err_n++; $display("FAIL rstmid_quiet: got HashCount=%0d Busy=%b expected 0/0", HashCount, Busy); end
  endtask

  initial begin
    work_v = {16{64'h0123_4567_89AB_CDEF}};
    step;
    test_reset;
    test_basic;
    test_target;
    test_backpressure;
    test_wrap;
    test_stop;
    test_restart;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
